sauria_cfg_reg2axil: RTL and testbench

- Converts Cheshire external reg-demux slave requests into AXI4-Lite master transactions on SAURIA's configuration slave port.
- Sits between Cheshire's `reg_ext_slv_req_o/rsp_i` port and SAURIA's configuration AXI4-Lite slave, upstream of it.
- Handles one transaction at a time; AW and W channels complete independently.
- A timeout guard protects the CPU from a hung accelerator.

---
 rtl/sauria_demo_pkg.sv | 22 ++
 rtl/sauria_cfg_reg2axil.sv | 246 ++++++++++++++++++++++++
 tb/tb_sauria_cfg_reg2axil.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sauria_demo_pkg.sv
// Shared types and constants for the SAURIA demo integration blocks.
// Holds the reg-to-AXI-Lite bridge state encoding and AXI response codes.
package sauria_demo_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StWrResp,
      StRdAddr,
      StRdResp,
      StDone,
      StDrain
   } cfg_bridge_state_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Read data returned to the CPU when the accelerator fails to answer in time.
   localparam logic [31:0] CFG_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sauria_cfg_reg2axil.sv
// Bridges single Cheshire reg-bus requests onto SAURIA's AXI4-Lite config port,
// one transaction at a time, with a timeout guard and post-timeout drain.
module sauria_cfg_reg2axil
   import sauria_demo_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int unsigned           TIMEOUT_CYCLES = 1024,
   localparam int unsigned          STRB           = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  reg_valid_i,
   input  logic                  reg_write_i,
   input  logic [ADDR_WIDTH-1:0] reg_addr_i,
   input  logic [DATA_WIDTH-1:0] reg_wdata_i,
   input  logic [STRB-1:0]       reg_wstrb_i,
   output logic                  reg_ready_o,
   output logic [DATA_WIDTH-1:0] reg_rdata_o,
   output logic                  reg_error_o,
   output logic [ADDR_WIDTH-1:0] awaddr_o,
   output logic [2:0]            awprot_o,
   output logic                  awvalid_o,
   input  logic                  awready_i,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic [STRB-1:0]       wstrb_o,
   output logic                  wvalid_o,
   input  logic                  wready_i,
   input  logic [1:0]            bresp_i,
   input  logic                  bvalid_i,
   output logic                  bready_o,
   output logic [ADDR_WIDTH-1:0] araddr_o,
   output logic [2:0]            arprot_o,
   output logic                  arvalid_o,
   input  logic                  arready_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic [1:0]            rresp_i,
   input  logic                  rvalid_i,
   output logic                  rready_o,
   output logic                  busy_o
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] CntLast =
      (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
   localparam bit TimeoutEn = (TIMEOUT_CYCLES > 0);

   cfg_bridge_state_e state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  write_q, write_d;
   logic                  drain_q, drain_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, reg_rdata_q, reg_rdata_d;
   logic [STRB-1:0]       wstrb_q, wstrb_d;
   logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
   logic                  bready_q, bready_d, rready_q, rready_d;
   logic                  reg_ready_q, reg_ready_d, reg_error_q, reg_error_d;
   logic                  busy_q, busy_d;

   logic                  aw_hs, w_hs, ar_hs;
   logic                  addr_borrow, addr_bad, timeout_hit, take_timeout;
   logic [ADDR_WIDTH-1:0] axi_addr;

   // The borrow out of the rebase subtraction flags addresses below BASE_ADDR.
   assign {addr_borrow, axi_addr} = {1'b0, reg_addr_i} - {1'b0, BASE_ADDR};
   assign addr_bad    = (reg_addr_i[1:0] != 2'b00) || addr_borrow;
   assign timeout_hit = TimeoutEn && (cnt_q >= CntLast);

   assign aw_hs = awvalid_q & awready_i;
   assign w_hs  = wvalid_q & wready_i;
   assign ar_hs = arvalid_q & arready_i;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      drain_d      = drain_q;
      awaddr_d     = awaddr_q;
      araddr_d     = araddr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      awvalid_d    = awvalid_q & ~aw_hs;
      wvalid_d     = wvalid_q & ~w_hs;
      arvalid_d    = arvalid_q & ~ar_hs;
      bready_d     = bready_q;
      rready_d     = rready_q;
      reg_rdata_d  = reg_rdata_q;
      reg_error_d  = reg_error_q;
      take_timeout = 1'b0;

      if (state_q inside {StWr, StWrResp, StRdAddr, StRdResp} && (cnt_q < CntLast)) begin
         cnt_d = cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (reg_valid_i) begin
               write_d     = reg_write_i;
               drain_d     = 1'b0;
               cnt_d       = '0;
               reg_rdata_d = '0;
               reg_error_d = 1'b0;
               if (addr_bad) begin
                  state_d     = StDone;
                  reg_error_d = 1'b1;
               end else if (reg_write_i) begin
                  state_d   = StWr;
                  awaddr_d  = axi_addr;
                  wdata_d   = reg_wdata_i;
                  wstrb_d   = reg_wstrb_i;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = StRdAddr;
                  araddr_d  = axi_addr;
                  arvalid_d = 1'b1;
               end
            end
         end
         StWr: begin
            if (!awvalid_d && !wvalid_d) begin
               state_d  = StWrResp;
               bready_d = 1'b1;
            end else if (timeout_hit) begin
               take_timeout = 1'b1;
            end
         end
         StWrResp: begin
            if (bvalid_i) begin
               state_d     = StDone;
               bready_d    = 1'b0;
               reg_error_d = (bresp_i != AXI_RESP_OKAY);
            end else if (timeout_hit) begin
               take_timeout = 1'b1;
            end
         end
         StRdAddr: begin
            if (ar_hs) begin
               state_d  = StRdResp;
               rready_d = 1'b1;
            end else if (timeout_hit) begin
               take_timeout = 1'b1;
            end
         end
         StRdResp: begin
            if (rvalid_i) begin
               state_d     = StDone;
               rready_d    = 1'b0;
               reg_rdata_d = rdata_i;
               reg_error_d = (rresp_i != AXI_RESP_OKAY);
            end else if (timeout_hit) begin
               take_timeout = 1'b1;
            end
         end
         StDone: begin
            if (drain_q) begin
               state_d  = StDrain;
               bready_d = write_q;
               rready_d = ~write_q;
            end else begin
               state_d = StIdle;
            end
         end
         StDrain: begin
            // Pending valids keep themselves up via the defaults; only the response ends the drain.
            if ((bready_q && bvalid_i) || (rready_q && rvalid_i)) begin
               state_d  = StIdle;
               bready_d = 1'b0;
               rready_d = 1'b0;
               drain_d  = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      if (take_timeout) begin
         state_d     = StDone;
         drain_d     = 1'b1;
         bready_d    = 1'b0;
         rready_d    = 1'b0;
         reg_error_d = 1'b1;
         reg_rdata_d = DATA_WIDTH'(CFG_TIMEOUT_RDATA);
      end

      reg_ready_d = (state_d == StDone);
      busy_d      = (state_d != StIdle);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         drain_q     <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         reg_ready_q <= 1'b0;
         reg_rdata_q <= '0;
         reg_error_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         drain_q     <= drain_d;
         awaddr_q    <= awaddr_d;
         araddr_q    <= araddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         reg_ready_q <= reg_ready_d;
         reg_rdata_q <= reg_rdata_d;
         reg_error_q <= reg_error_d;
         busy_q      <= busy_d;
      end
   end

   assign reg_ready_o = reg_ready_q;
   assign reg_rdata_o = reg_rdata_q;
   assign reg_error_o = reg_error_q;
   assign awaddr_o    = awaddr_q;
   assign awprot_o    = 3'b000;
   assign awvalid_o   = awvalid_q;
   assign wdata_o     = wdata_q;
   assign wstrb_o     = wstrb_q;
   assign wvalid_o    = wvalid_q;
   assign bready_o    = bready_q;
   assign araddr_o    = araddr_q;
   assign arprot_o    = 3'b000;
   assign arvalid_o   = arvalid_q;
   assign rready_o    = rready_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_sauria_cfg_reg2axil.sv
// Self-checking bench for sauria_cfg_reg2axil: scripted reg requests against a
// configurable AXI4-Lite slave, with expected results queued in a scoreboard.
module tb_sauria_cfg_reg2axil;
   import sauria_demo_pkg::*;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        reg_valid = 1'b0, reg_write = 1'b0;
   logic [31:0] reg_addr = '0, reg_wdata = '0;
   logic [3:0]  reg_wstrb = '0;
   logic        reg_ready_o, reg_error_o;
   logic [31:0] reg_rdata_o;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, arvalid, bready, rready, busy;
   logic        awready, wready, arready, bvalid, rvalid;
   logic [1:0]  bresp, rresp;

   sauria_cfg_reg2axil #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .BASE_ADDR     (32'h0),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .reg_valid_i(reg_valid),
      .reg_write_i(reg_write),
      .reg_addr_i (reg_addr),
      .reg_wdata_i(reg_wdata),
      .reg_wstrb_i(reg_wstrb),
      .reg_ready_o(reg_ready_o),
      .reg_rdata_o(reg_rdata_o),
      .reg_error_o(reg_error_o),
      .awaddr_o   (awaddr),
      .awprot_o   (awprot),
      .awvalid_o  (awvalid),
      .awready_i  (awready),
      .wdata_o    (wdata),
      .wstrb_o    (wstrb),
      .wvalid_o   (wvalid),
      .wready_i   (wready),
      .bresp_i    (bresp),
      .bvalid_i   (bvalid),
      .bready_o   (bready),
      .araddr_o   (araddr),
      .arprot_o   (arprot),
      .arvalid_o  (arvalid),
      .arready_i  (arready),
      .rdata_i    (rdata),
      .rresp_i    (rresp),
      .rvalid_i   (rvalid),
      .rready_o   (rready),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
      bit          chk_rdata;
      int          lat;
   } exp_t;
   exp_t sb_q[$];
   exp_t e;

   // Slave configuration and observation
   int          aw_lat = 0, w_lat = 0;
   bit          ar_hang = 1'b0, b_hang = 1'b0;
   logic [1:0]  b_q[$];
   logic [33:0] r_q[$];
   int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
   logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
   logic [3:0]  last_wstrb = '0;

   // Handshakes are judged at the negedge; slave inputs change 1ns after posedge.
   initial begin
      bit aw_f, w_f, ar_f, b_f, r_f, rst_s, aw_p, w_p, ar_p;
      int aw_w, w_w;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_p = 0; w_p = 0; ar_p = 0; aw_w = 0; w_w = 0;
      forever begin
         @(negedge clk);
         rst_s = rst;
         aw_f = awvalid && awready;
         w_f  = wvalid && wready;
         ar_f = arvalid && arready;
         b_f  = bvalid && bready;
         r_f  = rvalid && rready;
         if (aw_f) begin aw_cnt++; last_awaddr = awaddr; end
         if (w_f) begin w_cnt++; last_wdata = wdata; last_wstrb = wstrb; end
         if (ar_f) begin ar_cnt++; last_araddr = araddr; end
         if (b_f) b_cnt++;
         if (r_f) r_cnt++;
         @(posedge clk);
         #1;
         if (rst_s) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_p = 0; w_p = 0; ar_p = 0; aw_w = 0; w_w = 0;
         end else begin
            if (aw_f) begin aw_p = 1; aw_w = 0; end
            if (w_f) begin w_p = 1; w_w = 0; end
            if (ar_f) ar_p = 1;
            awready = 0;
            if (awvalid) begin
               if (aw_w >= aw_lat) awready = 1;
               else aw_w++;
            end
            wready = 0;
            if (wvalid) begin
               if (w_w >= w_lat) wready = 1;
               else w_w++;
            end
            arready = arvalid && !ar_hang;
            if (b_f) bvalid = 0;
            if (aw_p && w_p && !bvalid && !b_hang) begin
               bvalid = 1;
               bresp  = (b_q.size() > 0) ? b_q.pop_front() : AXI_RESP_OKAY;
               aw_p = 0; w_p = 0;
            end
            if (r_f) rvalid = 0;
            if (ar_p && !rvalid) begin
               rvalid = 1;
               {rresp, rdata} = (r_q.size() > 0) ? r_q.pop_front() : {AXI_RESP_OKAY, 32'h0};
               ar_p = 0;
            end
         end
      end
   end

   int          t0;
   logic [31:0] o_rd;
   bit          o_er, o_ok;
   int          o_lat;

   task automatic start_req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [31:0] exp_rd,
                            input bit exp_er, input bit chk_rd, input int exp_lat);
      exp_t x;
      @(posedge clk);
      #1;
      reg_valid = 1; reg_write = wr; reg_addr = addr; reg_wdata = data; reg_wstrb = strb;
      t0 = cyc;
      x.rdata = exp_rd; x.err = exp_er; x.chk_rdata = chk_rd; x.lat = exp_lat;
      sb_q.push_back(x);
   endtask

   task automatic wait_ready(input int budget);
      o_ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (reg_ready_o) begin
            o_rd = reg_rdata_o; o_er = reg_error_o; o_lat = cyc - t0; o_ok = 1;
            break;
         end
      end
   endtask

   task automatic end_req();
      @(posedge clk);
      #1;
      reg_valid = 0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({reg_ready_o, reg_error_o, busy, awvalid, wvalid, arvalid, bready, rready} !== 8'h0)
         begin failures++; $display("FAIL reset_ctrl: got %b required 0",
            {reg_ready_o, reg_error_o, busy, awvalid, wvalid, arvalid, bready, rready}); end
      checks++;
      if ({reg_rdata_o, awaddr, wdata, araddr, wstrb, awprot, arprot} !== '0) begin
         failures++; $display("FAIL reset_data: got %h required 0",
            {reg_rdata_o, awaddr, wdata, araddr, wstrb, awprot, arprot}); end
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   task automatic test_write_basic();
      start_req(1, 32'h10, 32'hA5A5_0001, 4'hF, '0, 0, 0, 3);
      wait_ready(40);
      end_req();
      e = sb_q.pop_front();
      checks++;
      if (!o_ok || o_er !== e.err) begin failures++;
         $display("FAIL wr_basic_err: got ok=%0d err=%0d required err=%0d", o_ok, o_er, e.err); end
      checks++;
      if (o_lat != e.lat) begin failures++;
         $display("FAIL wr_basic_lat: got %0d required %0d", o_lat, e.lat); end
      checks++;
      if (last_awaddr !== 32'h10) begin failures++;
         $display("FAIL wr_basic_awaddr: got %h required 00000010", last_awaddr); end
      checks++;
      if (last_wdata !== 32'hA5A5_0001 || last_wstrb !== 4'hF) begin failures++;
         $display("FAIL wr_basic_wdata: got %h/%h required a5a50001/f", last_wdata, last_wstrb); end
   endtask

   task automatic test_write_skew();
      for (int k = 0; k < 2; k++) begin
         int a0, w0;
         a0 = aw_cnt; w0 = w_cnt;
         aw_lat = (k == 0) ? 0 : 3;
         w_lat  = (k == 0) ? 4 : 0;
         start_req(1, 32'h30 + 32'(4 * k), 32'h5EED_0000 + 32'(k), 4'h3, '0, 0, 0, -1);
         wait_ready(40);
         end_req();
         e = sb_q.pop_front();
         checks++;
         if (!o_ok || o_er !== e.err) begin failures++;
            $display("FAIL wr_skew%0d_err: got ok=%0d err=%0d required 0", k, o_ok, o_er); end
         checks++;
         if (aw_cnt - a0 != 1 || w_cnt - w0 != 1) begin failures++;
            $display("FAIL wr_skew%0d_hs: got aw=%0d w=%0d required 1/1", k,
               aw_cnt - a0, w_cnt - w0); end
         checks++;
         if (last_awaddr !== 32'h30 + 32'(4 * k) || last_wdata !== 32'h5EED_0000 + 32'(k)) begin
            failures++;
            $display("FAIL wr_skew%0d_data: got %h/%h", k, last_awaddr, last_wdata); end
      end
      aw_lat = 0; w_lat = 0;
   endtask

   task automatic test_read_slverr();
      r_q.push_back({AXI_RESP_SLVERR, 32'h1234_5678});
      start_req(0, 32'h20, '0, '0, 32'h1234_5678, 1, 1, 3);
      wait_ready(40);
      end_req();
      e = sb_q.pop_front();
      checks++;
      if (!o_ok || o_er !== e.err || o_rd !== e.rdata) begin failures++;
         $display("FAIL rd_slverr: got ok=%0d err=%0d rdata=%h required err=1 rdata=%h",
            o_ok, o_er, o_rd, e.rdata); end
      checks++;
      if (o_lat != e.lat || last_araddr !== 32'h20) begin failures++;
         $display("FAIL rd_slverr_lat_addr: got lat=%0d addr=%h required 3/20", o_lat, last_araddr);
      end
   endtask

   task automatic test_misaligned();
      int a0;
      a0 = ar_cnt;
      start_req(0, 32'h22, '0, '0, '0, 1, 0, 1);
      wait_ready(20);
      end_req();
      repeat (3) @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (!o_ok || o_er !== e.err || o_lat != e.lat) begin failures++;
         $display("FAIL misaligned: got ok=%0d err=%0d lat=%0d required err=1 lat=1",
            o_ok, o_er, o_lat); end
      checks++;
      if (ar_cnt != a0 || arvalid !== 1'b0) begin failures++;
         $display("FAIL misaligned_noaxi: got ar_hs=%0d required 0", ar_cnt - a0); end
   endtask

   task automatic test_back_to_back();
      b_q.push_back(AXI_RESP_OKAY);
      b_q.push_back(AXI_RESP_SLVERR);
      r_q.push_back({AXI_RESP_OKAY, 32'h0BAD_F00D});
      for (int k = 0; k < 3; k++) begin
         start_req(k < 2, 32'h100 + 32'(4 * k), 32'h0000_1000 + 32'(k), 4'hF,
                   (k == 2) ? 32'h0BAD_F00D : 32'h0, k == 1, k == 2, 3);
         wait_ready(40);
         e = sb_q.pop_front();
         checks++;
         if (!o_ok || o_er !== e.err || o_lat != e.lat || (e.chk_rdata && o_rd !== e.rdata)) begin
            failures++;
            $display("FAIL b2b_%0d: got ok=%0d err=%0d lat=%0d rdata=%h required err=%0d lat=%0d rdata=%h",
               k, o_ok, o_er, o_lat, o_rd, e.err, e.lat, e.rdata); end
      end
      end_req();
   endtask

   task automatic test_timeout();
      int a0, r0;
      bit held;
      a0 = ar_cnt; r0 = r_cnt;
      ar_hang = 1;
      r_q.push_back({AXI_RESP_OKAY, 32'hBAD0_0001});
      r_q.push_back({AXI_RESP_OKAY, 32'h0000_CAFE});
      start_req(0, 32'h40, '0, '0, 32'hDEAD_BEEF, 1, 1, TO + 1);
      wait_ready(40);
      end_req();
      e = sb_q.pop_front();
      checks++;
      if (!o_ok || o_er !== e.err || o_rd !== e.rdata) begin failures++;
         $display("FAIL timeout_resp: got ok=%0d err=%0d rdata=%h required err=1 rdata=deadbeef",
            o_ok, o_er, o_rd); end
      checks++;
      if (o_lat != e.lat) begin failures++;
         $display("FAIL timeout_lat: got %0d required %0d", o_lat, e.lat); end
      start_req(0, 32'h44, '0, '0, 32'h0000_CAFE, 0, 1, -1);
      held = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (busy !== 1'b1 || reg_ready_o !== 1'b0 || arvalid !== 1'b1) held = 0;
      end
      checks++;
      if (!held) begin failures++;
         $display("FAIL drain_hold: got busy=%0d ready=%0d arvalid=%0d required 1/0/1",
            busy, reg_ready_o, arvalid); end
      ar_hang = 0;
      wait_ready(40);
      end_req();
      e = sb_q.pop_front();
      checks++;
      if (!o_ok || o_er !== e.err || o_rd !== e.rdata) begin failures++;
         $display("FAIL after_drain: got ok=%0d err=%0d rdata=%h required err=0 rdata=%h",
            o_ok, o_er, o_rd, e.rdata); end
      checks++;
      if (ar_cnt - a0 != 2 || r_cnt - r0 != 2 || last_araddr !== 32'h44) begin failures++;
         $display("FAIL drain_hs: got ar=%0d r=%0d addr=%h required 2/2/44",
            ar_cnt - a0, r_cnt - r0, last_araddr); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      b_hang = 1;
      start_req(1, 32'h50, 32'h7777_0000, 4'hF, '0, 0, 0, -1);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bready === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL rst_mid_wrresp: got bready=0 required 1"); end
      @(posedge clk);
      #1;
      rst = 1; reg_valid = 0;
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      checks++;
      if ({awvalid, wvalid, arvalid, bready, rready, busy, reg_ready_o} !== 7'h0) begin failures++;
         $display("FAIL rst_mid_clear: got %b required 0",
            {awvalid, wvalid, arvalid, bready, rready, busy, reg_ready_o}); end
      sb_q.delete();
      b_hang = 0;
      r_q.push_back({AXI_RESP_OKAY, 32'h600D_0060});
      start_req(0, 32'h60, '0, '0, 32'h600D_0060, 0, 1, 3);
      wait_ready(40);
      end_req();
      e = sb_q.pop_front();
      checks++;
      if (!o_ok || o_er !== e.err || o_rd !== e.rdata || o_lat != e.lat) begin failures++;
         $display("FAIL rst_mid_read: got ok=%0d err=%0d rdata=%h lat=%0d required 0/%h/3",
            o_ok, o_er, o_rd, o_lat, e.rdata); end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_write_skew();
      test_read_slverr();
      test_misaligned();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
